// File: rtl/datapath_pkg.sv
// Shared datapath constants used by the register file, bus mux and control unit.
//   DATA_WIDTH : default register/bus width
//   NUM_REGS   : default number of general-purpose registers
//   R0_IDX     : index of R0, the register masked to zero in base-address mode
package datapath_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned R0_IDX     = 0;

endpackage

// File: rtl/reg_cell.sv
// Single WIDTH-bit storage register with load enable.
// Ports:
//   clk    : clock, rising edge
//   clr    : asynchronous active-high clear, forces q to 0
//   enable : load d on the next rising edge
//   d      : data in
//   q      : registered data out
module reg_cell
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_ba.sv
// General-purpose register file with one write port, two combinational read ports
// (optional write-to-read bypass), R0 base-address masking on port A, and a
// pending-write scoreboard for load-use stall detection.
// Ports:
//   clk, clr            : clock / asynchronous active-high clear
//   wr_en, wr_addr,
//   wr_data             : synchronous write port
//   ra_addr, ra_data    : read port A (zeroed for R0 when ba_out is high)
//   ba_out              : base-address mode select
//   rb_addr, rb_data    : read port B (never masked)
//   busy_set, busy_addr : mark a register as awaiting a write
//   ra_busy, rb_busy    : pending flag of the register addressed by each port
//   busy_cnt            : registered count of pending registers
// DEPTH must be a power of two and at least 2.
module reg_file_ba
  import datapath_pkg::*;
#(
  parameter  int unsigned WIDTH  = DATA_WIDTH,
  parameter  int unsigned DEPTH  = NUM_REGS,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic             ba_out,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr,
  output logic             ra_busy,
  output logic             rb_busy,
  output logic [AW:0]      busy_cnt
);

  logic [WIDTH-1:0] regs_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    reg_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk   (clk),
      .clr   (clr),
      .enable(wr_en && (wr_addr == AW'(i))),
      .d     (wr_data),
      .q     (regs_q[i])
    );
  end

  // Same-cycle write hits on each read port; only honoured when bypass is built in.
  logic hit_a, hit_b;
  assign hit_a = (BYPASS != 0) && wr_en && (wr_addr == ra_addr);
  assign hit_b = (BYPASS != 0) && wr_en && (wr_addr == rb_addr);

  logic [WIDTH-1:0] ra_raw, rb_raw;
  assign ra_raw = hit_a ? wr_data : regs_q[ra_addr];
  assign rb_raw = hit_b ? wr_data : regs_q[rb_addr];

  // Mask is applied after the bypass so a forwarded R0 write still reads as zero.
  always_comb begin
    ra_data = ra_raw;
    if (ba_out && (ra_addr == AW'(R0_IDX))) begin
      ra_data = '0;
    end
  end

  assign rb_data = rb_raw;

  // Scoreboard
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    // Applied last: a load issued in the same cycle as the write keeps the bit set.
    if (busy_set) begin
      busy_d[busy_addr] = 1'b1;
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + (AW + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // A write landing this cycle resolves the hazard through the bypass.
  assign ra_busy  = busy_q[ra_addr] & ~hit_a;
  assign rb_busy  = busy_q[rb_addr] & ~hit_b;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_ba.sv
module tb_reg_file_ba;

  localparam int W = 32;
  localparam int D = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic [A-1:0] ra_addr, rb_addr, busy_addr;
  logic         ba_out, busy_set;

  logic [W-1:0] ra_b, rb_b, ra_n, rb_n;
  logic         rab_b, rbb_b, rab_n, rbb_n;
  logic [A:0]   cnt_b, cnt_n;

  always #5 clk = ~clk;

  reg_file_ba #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) u_dut_byp (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(ra_addr), .ra_data(ra_b), .ba_out(ba_out), .rb_addr(rb_addr), .rb_data(rb_b),
    .busy_set(busy_set), .busy_addr(busy_addr), .ra_busy(rab_b), .rb_busy(rbb_b),
    .busy_cnt(cnt_b)
  );

  reg_file_ba #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) u_dut_nb (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(ra_addr), .ra_data(ra_n), .ba_out(ba_out), .rb_addr(rb_addr), .rb_data(rb_n),
    .busy_set(busy_set), .busy_addr(busy_addr), .ra_busy(rab_n), .rb_busy(rbb_n),
    .busy_cnt(cnt_n)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: architectural register contents and set of pending registers.
  logic [W-1:0] mem [D];
  logic [D-1:0] pend;

  typedef struct {
    logic         we;
    logic [A-1:0] wa;
    logic [W-1:0] wd;
    logic [A-1:0] ra;
    logic [A-1:0] rb;
    logic         ba;
    logic         bs;
    logic [A-1:0] badr;
    logic [W-1:0] e_ra;
    logic [W-1:0] e_rb;
    logic [W-1:0] e_ra_nb;
    logic         e_rab;
    logic         e_rbb;
    logic [A:0]   e_cnt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) mem[i] = '0;
    pend = '0;
  endtask

  function automatic logic [W-1:0] model_read(input logic [A-1:0] a, input bit byp,
                                               input bit port_a);
    if (port_a && ba_out && a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  function automatic logic model_busy(input logic [A-1:0] a, input bit byp);
    return pend[a] && !(byp && wr_en && wr_addr == a);
  endfunction

  task automatic check_model();
    logic [A:0] n;
    n = (A + 1)'($countones(pend));
    chk("byp_ra_data", ra_b, model_read(ra_addr, 1, 1));
    chk("byp_rb_data", rb_b, model_read(rb_addr, 1, 0));
    chk("byp_ra_busy", W'(rab_b), W'(model_busy(ra_addr, 1)));
    chk("byp_rb_busy", W'(rbb_b), W'(model_busy(rb_addr, 1)));
    chk("byp_busy_cnt", W'(cnt_b), W'(n));
    chk("nb_ra_data", ra_n, model_read(ra_addr, 0, 1));
    chk("nb_rb_data", rb_n, model_read(rb_addr, 0, 0));
    chk("nb_ra_busy", W'(rab_n), W'(model_busy(ra_addr, 0)));
    chk("nb_rb_busy", W'(rbb_n), W'(model_busy(rb_addr, 0)));
    chk("nb_busy_cnt", W'(cnt_n), W'(n));
  endtask

  task automatic model_edge();
    if (!clr) begin
      if (wr_en) begin
        mem[wr_addr]  = wr_data;
        pend[wr_addr] = 1'b0;
      end
      if (busy_set) pend[busy_addr] = 1'b1;
    end
  endtask

  task automatic apply(input vec_t v);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    ra_addr = v.ra; rb_addr = v.rb; ba_out = v.ba;
    busy_set = v.bs; busy_addr = v.badr;
  endtask

  // Called at a falling edge with inputs applied; checks, then advances one clock.
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input logic [A-1:0] ra, input logic [A-1:0] rb);
    wr_en = 0; wr_addr = 0; wr_data = 0; ra_addr = ra; rb_addr = rb;
    ba_out = 0; busy_set = 0; busy_addr = 0;
  endtask

  initial begin
    //           we wa  wd            ra rb ba bs ba  e_ra          e_rb          e_ra_nb       rab rbb cnt
    tbl[0]  = '{0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0};
    tbl[1]  = '{1, 5, 32'hDEADBEEF, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0};
    tbl[2]  = '{0, 0, 32'h0,        5, 5, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    tbl[3]  = '{1, 0, 32'h00001234, 5, 5, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    tbl[4]  = '{0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h00001234, 32'h0,        0, 0, 0};
    tbl[5]  = '{0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h00001234, 32'h00001234, 32'h00001234, 0, 0, 0};
    tbl[6]  = '{1, 3, 32'hA5A5A5A5, 3, 3, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        0, 0, 0};
    tbl[7]  = '{0, 0, 32'h0,        3, 3, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0};
    tbl[8]  = '{0, 0, 32'h0,        2, 2, 0, 1, 2, 32'h0,        32'h0,        32'h0,        0, 0, 0};
    tbl[9]  = '{0, 0, 32'h0,        2, 2, 0, 1, 7, 32'h0,        32'h0,        32'h0,        1, 1, 1};
    tbl[10] = '{0, 0, 32'h0,        2, 7, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 2};
    tbl[11] = '{1, 2, 32'h00000022, 2, 7, 0, 0, 0, 32'h00000022, 32'h0,        32'h0,        0, 1, 2};
    tbl[12] = '{0, 0, 32'h0,        2, 7, 0, 0, 0, 32'h00000022, 32'h0,        32'h00000022, 0, 1, 1};
    tbl[13] = '{1, 4, 32'h00000044, 4, 2, 0, 1, 4, 32'h00000044, 32'h00000022, 32'h0,        0, 0, 1};
    tbl[14] = '{0, 0, 32'h0,        4, 2, 0, 0, 0, 32'h00000044, 32'h00000022, 32'h00000044, 1, 0, 2};

    // Reset state, checked while clr is held
    clr = 1'b1;
    idle(0, 0);
    model_reset();
    @(negedge clk);
    #1;
    check_model();
    @(negedge clk);
    clr = 1'b0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
      #1;
      chk("tbl_ra_data", ra_b, tbl[i].e_ra);
      chk("tbl_rb_data", rb_b, tbl[i].e_rb);
      chk("tbl_ra_nb", ra_n, tbl[i].e_ra_nb);
      chk("tbl_ra_busy", W'(rab_b), W'(tbl[i].e_rab));
      chk("tbl_rb_busy", W'(rbb_b), W'(tbl[i].e_rbb));
      chk("tbl_busy_cnt", W'(cnt_b), W'(tbl[i].e_cnt));
      check_model();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
    end

    // Asynchronous clear takes effect with no clock edge
    idle(5, 4);
    #1;
    chk("pre_clr_ra", ra_b, 32'hDEADBEEF);
    #1 clr = 1'b1;
    #1;
    chk("async_clr_ra", ra_b, 32'h0);
    chk("async_clr_rb", rb_b, 32'h0);
    chk("async_clr_cnt", W'(cnt_b), 32'h0);
    model_reset();
    check_model();
    @(negedge clk);
    clr = 1'b0;

    // Write R9 with a pending load, clear mid-cycle, then write R1
    idle(0, 0);
    wr_en = 1; wr_addr = 9; wr_data = 32'h99999999; busy_set = 1; busy_addr = 6;
    step();
    idle(9, 6);
    #1;
    chk("pre_clr_r9", ra_b, 32'h99999999);
    chk("pre_clr_cnt", W'(cnt_b), 32'd1);
    #1 clr = 1'b1;
    #1 clr = 1'b0;
    model_reset();
    @(negedge clk);
    idle(0, 0);
    wr_en = 1; wr_addr = 1; wr_data = 32'h00001111;
    step();
    idle(9, 1);
    #1;
    chk("post_clr_r9", ra_b, 32'h0);
    chk("post_clr_r1", rb_b, 32'h00001111);
    chk("post_clr_cnt", W'(cnt_b), 32'h0);
    step();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_addr   = A'($urandom_range(0, D - 1));
      wr_data   = $urandom;
      ra_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : A'($urandom_range(0, D - 1));
      rb_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : A'($urandom_range(0, D - 1));
      ba_out    = $urandom_range(0, 1) != 0;
      busy_set  = $urandom_range(0, 1) != 0;
      busy_addr = ($urandom_range(0, 4) == 0) ? wr_addr : A'($urandom_range(0, D - 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_ba.md
# reg_file_ba

Parametrised general-purpose register file for the datapath, replacing the individual per-register instances (including the special R0) with one block. It provides one synchronous write port, two combinational read ports with optional write-to-read bypass, and R0 base-address masking on read port A (ld/st/addi with R0 as base reads as zero when `ba_out` is high). It also keeps a per-register pending-write scoreboard for the control unit's load-use stall logic.

## Interface
- `WIDTH`, default 32: data width of every register.
- `DEPTH`, default 16: number of registers; must be a power of two and at least 2. `AW = $clog2(DEPTH)` is derived locally and is not overridable.
- `BYPASS`, default 1: 1 forwards same-cycle write data to the read ports; 0 makes reads return the stored value only.
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high; clock `clk`.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  AW  write register index.
- `wr_data`  in  WIDTH  write data (BusMuxOut).
- `ra_addr`  in  AW  read port A index.
- `ra_data`  out  WIDTH  read port A data.
- `ba_out`  in  1  base-address mode; zeroes port A when `ra_addr`==0.
- `rb_addr`  in  AW  read port B index.
- `rb_data`  out  WIDTH  read port B data.
- `busy_set`  in  1  marks `busy_addr` as awaiting a write (load issued).
- `busy_addr`  in  AW  scoreboard index to mark.
- `ra_busy`  out  1  register at `ra_addr` is pending.
- `rb_busy`  out  1  register at `rb_addr` is pending.
- `busy_cnt`  out  AW+1  number of pending registers (registered).

## Operation
- Storage: DEPTH×WIDTH registers. On a rising edge with `wr_en`=1, `reg[wr_addr]` <= `wr_data`.
- R0 is a real writable register. Zeroing applies only to port A reads under `ba_out`.
- Port A raw value: if BYPASS=1, `wr_en`=1 and `wr_addr`==`ra_addr`, the raw value is `wr_data`; otherwise it is `reg[ra_addr]`.
- `ra_data` = 0 if `ba_out`=1 and `ra_addr`==0. Otherwise `ra_data` = port A raw value. The mask applies after the bypass.
- Port B uses the same bypass rule and is never masked. `ba_out` has no effect on B.
- Scoreboard: `busy[DEPTH-1:0]`.
  - Each rising edge: a write clears `busy[wr_addr]`, and `busy_set` sets `busy[busy_addr]`.
  - Same index written and set in the same cycle: the set wins, so the bit ends at 1 (a new load has been issued).
- `ra_busy` = `busy[ra_addr]` & ~(BYPASS & `wr_en` & `wr_addr`==`ra_addr`). `rb_busy` follows the same rule. With BYPASS=0 they equal the raw bit.
- `busy_cnt` <= popcount(busy_next) on each edge, so it always equals popcount(busy) and never drifts.
- `busy_set` on an already-busy register leaves it at 1 and does not change the count.

## Timing
- Write latency: 1 cycle. Data is visible from storage the cycle after the edge, and in the same cycle through the bypass.
- Reads, masking and busy flags are combinational from addresses, `wr_*` and `ba_out`. There is no clock-to-read latency.
- `clr` high asynchronously forces all registers to 0, `busy` to 0 and `busy_cnt` to 0. While `clr` is high, `wr_en` and `busy_set` are ignored.
- Reset values: `ra_data`=0 and `rb_data`=0 (unless bypassing a concurrent write), `ra_busy`=0, `rb_busy`=0, `busy_cnt`=0.
- `clr` asserted mid-operation discards any pending writes and scoreboard state. The first edge after `clr` falls behaves normally.

## Structure
- Shared package `datapath_pkg`: `R0_IDX`=0, and the default `WIDTH` and `DEPTH` constants shared with the bus mux and control unit.
- Sub-module `reg_cell`: one WIDTH-bit register with `clk`, `clr`, `enable` and `d`/`q`. It is instantiated DEPTH times, with `enable` = `wr_en` & (`wr_addr`==i).
- Decode, read muxes, bypass, mask and scoreboard live in the top module.

## Test plan
- Write 32'hDEADBEEF to R5. Next cycle, `ra_addr`=5 and `rb_addr`=5 -> both read 32'hDEADBEEF. Assert `clr` -> both read 0 immediately, without waiting for a clock edge.
- Write 32'h00001234 to R0. `ra_addr`=0 with `ba_out`=1 -> `ra_data`=0 while `rb_data`=32'h00001234. With `ba_out`=0 -> `ra_data`=32'h00001234.
- BYPASS=1: in the same cycle as a write of 32'hA5A5A5A5 to R3, `ra_addr`=3 -> `ra_data`=32'hA5A5A5A5. With BYPASS=0 -> the old value is read.
- Scoreboard: `busy_set` R2, then R7 -> `busy_cnt`=2 and `ra_busy`=1 for R2. A write to R2 -> `busy_cnt`=1, and `ra_busy`=0 in the write cycle when BYPASS=1.
- Simultaneous `busy_set` and write to R4 -> after the edge `busy[4]`=1, `busy_cnt` increments by 1, and the data is updated.
- Write R9, assert `clr` asynchronously mid-cycle, release it, write R1 -> R9 reads 0, R1 holds its new value, `busy_cnt`=0.
